// File: rtl/recv_port.sv
// recv_port: inter-PU link receiver; writes a framed payload into local DMEM.
// Defining RECV_CKSUM_EN adds a per-frame XOR trailer beat and the CSUM state.
module recv_port #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned ADDR_W  = 8,
  parameter logic [3:0]  PORT_ID = 4'h0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              l_valid,
  input  logic              l_sof,
  input  logic [WIDTH-1:0]  l_data,
  output logic              l_ready,
  input  logic [ADDR_W-1:0] base,
  output logic              dm_req,
  input  logic              dm_gnt,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [WIDTH-1:0]  dm_wd,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [7:0]        rx_len,
  input  logic              clr_err
);

  localparam int unsigned LEN_W = 8;

`ifdef RECV_CKSUM_EN
  // Drained frames also carry the trailer, so drain one beat past the payload.
  localparam logic [LEN_W-1:0] DRAIN_LAST = LEN_W'(0);
`else
  localparam logic [LEN_W-1:0] DRAIN_LAST = LEN_W'(1);
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DATA  = 2'd1,
    S_DRAIN = 2'd2
`ifdef RECV_CKSUM_EN
    , S_CSUM = 2'd3
`endif
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [LEN_W-1:0]    rem_q, rem_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [LEN_W-1:0]    rx_len_q, rx_len_d;
`ifdef RECV_CKSUM_EN
  logic [WIDTH-1:0]    xacc_q, xacc_d;
`endif

  logic                err_set;
  logic                take_hdr;
  logic                beat_hdr;
  logic                beat_dat;
  logic [3:0]          hdr_port;
  logic [LEN_W-1:0]    hdr_size;

  assign hdr_port = l_data[15:12];
  assign hdr_size = l_data[7:0];
  assign beat_hdr = l_valid & l_ready & l_sof;
  assign beat_dat = l_valid & l_ready & ~l_sof;

  assign busy   = (state_q != S_IDLE);
  assign done   = done_q;
  assign err    = err_q;
  assign rx_len = rx_len_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    rem_d    = rem_q;
    len_d    = len_q;
    done_d   = 1'b0;
    rx_len_d = rx_len_q;
    err_set  = 1'b0;
    take_hdr = 1'b0;
`ifdef RECV_CKSUM_EN
    xacc_d   = xacc_q;
`endif

    case (state_q)
      S_IDLE: take_hdr = beat_hdr;
      S_DATA: begin
        if (beat_hdr) begin
          err_set  = 1'b1;
          take_hdr = 1'b1;
        end else if (beat_dat) begin
          ptr_d = ptr_q + ADDR_W'(1);
          rem_d = rem_q - LEN_W'(1);
`ifdef RECV_CKSUM_EN
          xacc_d = xacc_q ^ l_data;
`endif
          if (rem_q == LEN_W'(1)) begin
`ifdef RECV_CKSUM_EN
            state_d = S_CSUM;
`else
            state_d  = S_IDLE;
            done_d   = 1'b1;
            rx_len_d = len_q;
`endif
          end
        end
      end
`ifdef RECV_CKSUM_EN
      S_CSUM: begin
        if (beat_hdr) begin
          err_set  = 1'b1;
          take_hdr = 1'b1;
        end else if (beat_dat) begin
          state_d  = S_IDLE;
          done_d   = 1'b1;
          rx_len_d = len_q;
          err_set  = (l_data != xacc_q);
        end
      end
`endif
      S_DRAIN: begin
        if (beat_hdr) begin
          take_hdr = 1'b1;
        end else if (beat_dat) begin
          rem_d = rem_q - LEN_W'(1);
          if (rem_q == DRAIN_LAST) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Header beat: starts a new frame, possibly aborting the current one
    if (take_hdr) begin
      state_d = S_IDLE;
      rem_d   = hdr_size;
      if (hdr_port == PORT_ID) begin
        ptr_d = base;
        len_d = hdr_size;
`ifdef RECV_CKSUM_EN
        xacc_d = '0;
`endif
        if (hdr_size != LEN_W'(0)) begin
          state_d = S_DATA;
        end else begin
`ifdef RECV_CKSUM_EN
          state_d = S_CSUM;
`else
          done_d   = 1'b1;
          rx_len_d = hdr_size;
`endif
        end
      end else if (hdr_size != LEN_W'(0)) begin
        state_d = S_DRAIN;
      end
    end

    // A new error beats a coincident clear
    if (err_set)      err_d = 1'b1;
    else if (clr_err) err_d = 1'b0;
    else              err_d = err_q;
  end

  // Link handshake and DMEM write port
  always_comb begin
    l_ready = 1'b1;
    dm_req  = 1'b0;
    dm_we   = 1'b0;
    dm_addr = '0;
    dm_wd   = '0;
    if (state_q == S_DATA) begin
      dm_req  = 1'b1;
      l_ready = dm_gnt | (l_valid & l_sof);
      if (l_valid && !l_sof && dm_gnt) begin
        dm_we   = 1'b1;
        dm_addr = ptr_q;
        dm_wd   = l_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q    <= '0;
      rem_q    <= '0;
      len_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      rx_len_q <= '0;
    end else begin
      ptr_q    <= ptr_d;
      rem_q    <= rem_d;
      len_q    <= len_d;
      done_q   <= done_d;
      err_q    <= err_d;
      rx_len_q <= rx_len_d;
    end
  end

`ifdef RECV_CKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) xacc_q <= '0;
    else        xacc_q <= xacc_d;
  end
`endif

endmodule

// File: doc/recv_port.md
# recv_port

Inter-PU link receiver: the far end of the PU `SEND addr, size, port` instruction. It accepts a framed word stream from a sending PU and checks that the frame's port matches this PU. It writes the payload into local data memory starting at a base address supplied by the local PU, arbitrating for the data-memory write port, and reports completion and errors. One instance sits beside each PU's data memory, between the interconnect and the DMEM write mux.

## Interface
- `WIDTH`, 16: data word width.
- `ADDR_W`, 8: data-memory address width.
- `PORT_ID`, 4'h0: port number this receiver answers to (4 bits).
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `l_valid`  in  1  sender has a beat on `l_data`.
- `l_sof`  in  1  beat is a frame header.
- `l_data`  in  WIDTH  beat data.
  - Header layout: [15:12] port, [11:8] reserved, [7:0] size (payload word count).
- `l_ready`  out  1  receiver accepts the current beat.
- `base`  in  ADDR_W  destination base address, sampled with the header.
- `dm_req`  out  1  request for the DMEM write port.
- `dm_gnt`  in  1  DMEM write port granted this cycle.
- `dm_we`  out  1  DMEM write strobe.
- `dm_addr`  out  ADDR_W  DMEM write address.
- `dm_wd`  out  WIDTH  DMEM write data.
- `busy`  out  1  frame in progress.
- `done`  out  1  one-cycle pulse: frame completed.
- `err`  out  1  sticky error flag.
- `rx_len`  out  8  size of the last completed frame.
- `clr_err`  in  1  synchronous clear of `err`.

## Operation
- A beat transfers when `l_valid && l_ready`.
- States: IDLE, DATA, CSUM (only with the macro), DRAIN.
- IDLE:
  - `l_ready`=1.
  - A beat with `l_sof`=0 is accepted and discarded.
  - Header with matching port: latch `base` into `ptr`, latch size into `rem` and `len`, clear `xacc`.
  - Matching header, size≠0 → DATA. Size=0 → complete immediately (CSUM first if the macro is enabled).
  - Non-matching port → DRAIN with `rem`=size; size=0 → stay in IDLE.
- DATA:
  - `dm_req`=1; `l_ready`=`dm_gnt`.
  - On each transfer: `dm_we`=1, `dm_addr`=`ptr`, `dm_wd`=`l_data`, all combinational in the same cycle.
  - Also on each transfer: `ptr`+=1 mod 2^ADDR_W (wraps, no error), `rem`-=1, `xacc`^=`l_data`.
  - Last word → CSUM if the macro is enabled, else complete.
- DRAIN: `l_ready`=1, beats discarded, no DMEM access. Leave after `rem` beats (+1 checksum beat with the macro), return to IDLE with no `done` and no `err`.
- Complete: return to IDLE, pulse `done`, update `rx_len` to `len`.
- `l_sof`=1 arriving in DATA, CSUM or DRAIN:
  - The current frame aborts with no `done`.
  - `err` is set, except in DRAIN.
  - The beat is processed as a new header under the IDLE rules in the same cycle.
  - In DATA the abort applies even when `dm_gnt`=0, and no DMEM write occurs.
- Words already written by an aborted frame remain in memory.
- `err` holds until `clr_err`; if a set and `clr_err` coincide, the set wins.
- `busy` = state≠IDLE.

## Timing
- Reset values: state IDLE, `l_ready`=1, `dm_req`=`dm_we`=0, `dm_addr`=0, `dm_wd`=0, `busy`=`done`=`err`=0, `rx_len`=0.
- Throughput: one word per cycle while `dm_gnt` stays high.
- A DMEM write occurs in the handshake cycle.
- `done` and the new `rx_len` appear in the cycle after the final beat (or size-0 header) transfers. They are registered, as is `err`.
- `base` is ignored after the header; changes mid-frame have no effect.
- Reset mid-frame: immediate return to IDLE. No `done`; partial writes stay in memory.

## Configuration
- `RECV_CKSUM_EN` defined:
  - Every frame, including a drained one and a size-0 one, ends with one trailer beat equal to the XOR of all payload words (0 for size 0).
  - The trailer is accepted in CSUM with `l_ready`=1 and is not written to memory.
  - A mismatch sets `err` in the same cycle `done` pulses; `done` still pulses.
- Undefined: no CSUM state, no trailer beat, no `xacc` logic. The frame completes on the last payload word.

## Test plan
- PORT_ID=2, `base`=8'h40, header 16'h2003, words 1111/2222/3333, `dm_gnt`=1 → writes to 40/41/42 in three consecutive cycles; `done` pulses once; `rx_len`=3; `err`=0.
- Same frame with `dm_gnt` low for 2 cycles before word 2 → `l_ready`=0 during the gap; no writes; data intact; `done` still pulses once.
- `base`=8'hFE, size 3 → writes to FE, FF, 00 (wrap), no error.
- Header port 5 with PORT_ID=2, size 4 → 4 beats consumed, `dm_we` never asserts, no `done`, `err`=0.
- `l_sof` header 16'h2001 after 1 of 3 words → `err`=1; the new 1-word frame writes to the newly sampled `base`; `done` pulses once; `rx_len`=1. `clr_err` then drives `err` to 0.
- With `RECV_CKSUM_EN`: words 00FF, 0F0F with trailer 0FF0 → `done`, `err`=0. With trailer 0000 → `done` and `err`=1.
